// File: rtl/alu_pkg.sv
// Shared ALU constants and the result-source indices that drive the result mux select.
package alu_pkg;

  localparam int WORD_W     = 32;
  localparam int MUX_SEL_W  = 4;
  localparam int MUX10_IN_W = 320;

  typedef enum logic [MUX_SEL_W-1:0] {
    SRC_ADD = 4'd0,
    SRC_SUB = 4'd1,
    SRC_AND = 4'd2,
    SRC_OR  = 4'd3,
    SRC_XOR = 4'd4,
    SRC_SLL = 4'd5,
    SRC_SRL = 4'd6,
    SRC_SRA = 4'd7,
    SRC_SLT = 4'd8,
    SRC_LUI = 4'd9
  } alu_src_e;

endpackage

// File: rtl/mux2_32.sv
// 32-bit 2:1 mux; an unknown select yields all-X rather than a merged word.
module mux2_32
  import alu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              sel,
  output logic [WORD_W-1:0] y
);

  // Explicit default keeps X on sel from collapsing to bits the inputs share.
  always_comb begin
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux10_32_sel.sv
// 10-input 32-bit select mux for the ALU result path: 4-level 2:1 tree plus a registered copy.
module mux10_32_sel
  import alu_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int WIDTH = WORD_W,
  parameter int SEL_W = MUX_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] a,
  input  logic [SEL_W-1:0]      s,
  output logic [WIDTH-1:0]      y,
  output logic [WIDTH-1:0]      y_q
);

  localparam int N_LEAF = 1 << SEL_W;

  logic [WIDTH-1:0] leaf [N_LEAF];
  logic [WIDTH-1:0] lvl1 [N_LEAF/2];
  logic [WIDTH-1:0] lvl2 [N_LEAF/4];
  logic [WIDTH-1:0] lvl3 [N_LEAF/8];

  // Leaves beyond the real inputs read as zero so out-of-range selects give 0.
  for (genvar i = 0; i < N_LEAF; i++) begin : g_leaf
    if (i < N_IN) begin : g_used
      assign leaf[i] = a[i*WIDTH +: WIDTH];
    end else begin : g_zero
      assign leaf[i] = '0;
    end
  end

  for (genvar i = 0; i < N_LEAF/2; i++) begin : g_l1
    mux2_32 u_mux (.a(leaf[2*i]), .b(leaf[2*i+1]), .sel(s[0]), .y(lvl1[i]));
  end

  for (genvar i = 0; i < N_LEAF/4; i++) begin : g_l2
    mux2_32 u_mux (.a(lvl1[2*i]), .b(lvl1[2*i+1]), .sel(s[1]), .y(lvl2[i]));
  end

  for (genvar i = 0; i < N_LEAF/8; i++) begin : g_l3
    mux2_32 u_mux (.a(lvl2[2*i]), .b(lvl2[2*i+1]), .sel(s[2]), .y(lvl3[i]));
  end

  mux2_32 u_root (.a(lvl3[0]), .b(lvl3[1]), .sel(s[3]), .y(y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_mux10_32_sel.sv
// Directed and random checks of the combinational select and the registered copy.
module tb_mux10_32_sel;

  logic         clk;
  logic         rst;
  logic [319:0] a;
  logic [3:0]   s;
  logic [31:0]  y;
  logic [31:0]  y_q;

  int checks   = 0;
  int failures = 0;
  logic [31:0] wv [10];

  mux10_32_sel dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .s   (s),
    .y   (y),
    .y_q (y_q)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pack_a();
    for (int i = 0; i < 10; i++) a[32*i +: 32] = wv[i];
  endtask

  task automatic fill_words(input logic [31:0] v);
    for (int i = 0; i < 10; i++) wv[i] = v;
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] all_x;
    rst = 1'b1;
    a   = '0;
    s   = '0;
    all_x = 'x;

    // reset held for two clocks
    @(negedge clk);
    check("reset_y_q_0", y_q, 32'h0);
    @(negedge clk);
    check("reset_y_q_1", y_q, 32'h0);

    // word isolation
    for (int i = 0; i < 10; i++) begin
      fill_words(32'hFFFF_FFFF);
      wv[i] = 32'hA5A5_0000 + i;
      pack_a();
      s = 4'(i);
      #1;
      check($sformatf("isolate_s%0d", i), y, 32'hA5A5_0000 + i);
    end

    // out of range selects
    a = '1;
    for (int v = 10; v < 16; v++) begin
      s = 4'(v);
      #1;
      check($sformatf("out_of_range_s%0d", v), y, 32'h0);
    end

    // boundary words
    fill_words(32'h0);
    wv[0] = 32'h0000_0001;
    wv[9] = 32'h8000_0000;
    pack_a();
    s = 4'd0;
    #1;
    check("boundary_s0", y, 32'h0000_0001);
    s = 4'd9;
    #1;
    check("boundary_s9", y, 32'h8000_0000);

    // random sweep
    for (int n = 0; n < 1024; n++) begin
      for (int i = 0; i < 10; i++) wv[i] = $urandom;
      pack_a();
      s = 4'($urandom_range(0, 15));
      #1;
      exp = (s < 4'd10) ? wv[s] : 32'h0;
      check($sformatf("random_%0d_s%0d", n, s), y, exp);
    end

    // unknown select; only meaningful on a 4-state simulator
    for (int i = 0; i < 10; i++) wv[i] = 32'h1000_0000 + 32'(i * 17);
    pack_a();
    s = 4'bx01x;
    #1;
    if ($isunknown(s)) check("x_select", y, all_x);
    s = 4'd5;
    #1;
    check("x_recover_s5", y, 32'h1000_0055);

    // registered path: release reset at a falling edge
    @(negedge clk);
    fill_words(32'h0BAD_F00D);
    wv[3] = 32'hDEAD_BEEF;
    pack_a();
    s   = 4'd3;
    rst = 1'b0;
    #1;
    check("y_q_before_first_edge", y_q, 32'h0);
    @(negedge clk);
    check("y_q_first_load", y_q, 32'hDEAD_BEEF);

    wv[7] = 32'h1234_5678;
    pack_a();
    s = 4'd7;
    @(negedge clk);
    check("y_q_second_load", y_q, 32'h1234_5678);

    // async reset mid-cycle
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("y_q_async_clear", y_q, 32'h0);
    check("y_during_reset", y, 32'h1234_5678);
    @(negedge clk);
    check("y_q_held_in_reset", y_q, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux10_32_sel.md
Name: mux10_32_sel

Overview:
- 10-input, 32-bit-wide one-hot-free select multiplexer used in the ALU result path.
- Picks one 32-bit word out of a flat 320-bit packed bus by a 4-bit select.
- The primary output is purely combinational. A registered copy is also provided for pipelined consumers.
- Any select outside 0..9 yields all-zeros.

Parameters:
- N_IN, 10, number of 32-bit input words; fixed at 10 for this block.
- WIDTH, 32, bits per word.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N_IN.

Ports:
- clk  input  1  single clock; used only by the registered output.
- rst  input  1  asynchronous, active-high reset; clears the registered output.
- a  input  320 (N_IN*WIDTH)  packed inputs; word i = a[32*i+31 : 32*i], so word 0 = a[31:0] and word 9 = a[319:288].
- s  input  4  select.
- y  output  32  combinational selected word.
- y_q  output  32  y registered on rising clk.

Behaviour:
- y is combinational with zero cycles latency, and has no dependence on clk or rst.
- For s in 0..9: y = a[32*s+31 : 32*s], bit-exact.
- For s in 10..15: y = 32'h0000_0000.
- If s contains X or Z: y = all-X. No silent default to a valid word.
- y must settle within the same delta/timestep as any change on a or s. A bench samples y 1 ns after stimulus using a 4-state (===) compare.
- Build structure: a 4-level tree of 2:1 32-bit muxes driven by s[0]..s[3], with unused leaves (words 10..15) tied to zero.
  - Equivalent flat case logic is acceptable provided behaviour is identical, including the X rule.
- y_q:
  - rst asserted (async, any time): y_q = 0 immediately, held while rst is high.
  - rst deasserted: on each rising clk, y_q <= y.
  - Reset released coincident with a clk edge: y_q stays 0 for that edge and loads on the next edge.
- There is no handshake and no state machine; the only storage is the 32-bit y_q register.
- No width truncation or extension on the data path: output width = WIDTH exactly.

Decomposition:
- Shared package alu_pkg holds:
  - WORD_W = 32
  - MUX_SEL_W = 4
  - MUX10_IN_W = 320
  - an enum of the ALU result-source indices 0..9 that drive s.
- Natural sub-module: mux2_32 (two 32-bit inputs, 1-bit select, 32-bit out). Instantiated 15 times in the tree; 6 of the leaves use zero-tied inputs.
- The top wrapper adds the y_q register and the packing/unpacking of a.

Test Plan:
- Word isolation: set word i = 32'hA5A5_0000 + i and all others = 32'hFFFF_FFFF; sweep s = 0..9 -> y = 32'hA5A5_0000 + s each time, within 1 ns.
- Out of range: a = all ones (320'h…FFFF); s = 10, 11, 12, 13, 14, 15 -> y = 32'h0000_0000 for every value.
- Random sweep: 1024 iterations of random a (ten 32-bit $random words) and random s. After 1 ns, y === model, where model = word s if s < 10, else 0. Zero mismatches required.
- Boundary words: a[31:0] = 32'h0000_0001, a[319:288] = 32'h8000_0000, rest 0; s = 0 -> 32'h0000_0001, s = 9 -> 32'h8000_0000. Catches off-by-one slicing.
- Registered path:
  - Hold rst = 1 for 2 clocks: y_q = 0.
  - Release rst with s = 3, word 3 = 32'hDEAD_BEEF: y_q = 32'hDEAD_BEEF after the first rising clk post-release.
  - Assert rst mid-cycle: y_q = 0 immediately, without waiting for clk.
- X propagation: s = 4'bx01x -> y === 32'hxxxx_xxxx; then s = 5 -> y = word 5 again.
